// File: rtl/fft8_seq.sv
// fft8_seq: loads 8 serial samples into the FFT buffer, then fires the three stage strobes and holds result-valid.
// Latency: each write is visible 1 cycle after its accept; s[0] at k+1, s[1] at k+1+P, s[2] at k+1+2P, res_vld at k+1+3P (P=STB_W+GAP).
// Backpressure: x_rdy only in LOAD with e high; DONE holds res_vld until res_rdy; e low freezes everything.
module fft8_seq #(
  parameter int DW    = 2,
  parameter int STB_W = 1,
  parameter int GAP   = 1
) (
  input  logic          c,
  input  logic          r,
  input  logic          e,
  input  logic          abort,
  input  logic [DW-1:0] x_in,
  input  logic          x_vld,
  output logic          x_rdy,
  output logic          buf_we,
  output logic [2:0]    buf_addr,
  output logic [DW-1:0] buf_wd,
  output logic          buf_clr,
  output logic [2:0]    s,
  output logic          res_vld,
  input  logic          res_rdy,
  output logic          busy,
  output logic [7:0]    frm_cnt
);

  typedef enum logic [2:0] {LOAD, DRAIN, STG0, STG1, STG2, DONE} state_t;

  // The phase counter restarts between the high and gap parts of a stage, so 4 bits cover both halves.
  localparam logic [3:0] STB_LAST = 4'(STB_W - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_smp_cnt, w_smp_cnt_nxt;
  logic [3:0]    r_phase, w_phase_nxt;
  logic          r_we, w_we_nxt;
  logic [2:0]    r_addr, w_addr_nxt;
  logic [DW-1:0] r_wd, w_wd_nxt;
  logic          r_clr, w_clr_nxt;
  logic [2:0]    r_s, w_s_nxt;
  logic          r_res, w_res_nxt;
  logic [7:0]    r_frm, w_frm_nxt;

  logic w_acc, w_stg, w_hi, w_hi_end, w_gap_end;

  assign x_rdy     = (r_state == LOAD) & e & r;
  assign w_acc     = x_vld & x_rdy;
  assign w_stg     = (r_state == STG0) | (r_state == STG1) | (r_state == STG2);
  assign w_hi      = |r_s;
  assign w_hi_end  = w_stg & w_hi & (r_phase == STB_LAST);
  assign w_gap_end = w_stg & ~w_hi & (r_phase == GAP_LAST);

  // State register
  always_ff @(posedge c or negedge r) begin
    if (!r) r_state <= LOAD;
    else    r_state <= w_state_nxt;
  end

  // Next-state logic: abort overrides everything, e low holds the state
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = LOAD;
    end else if (e) begin
      case (r_state)
        LOAD:    if (w_acc && r_smp_cnt == 3'd7) w_state_nxt = DRAIN;
        DRAIN:   w_state_nxt = STG0;
        STG0:    if (w_gap_end) w_state_nxt = STG1;
        STG1:    if (w_gap_end) w_state_nxt = STG2;
        STG2:    if (w_gap_end) w_state_nxt = DONE;
        DONE:    if (res_rdy) w_state_nxt = LOAD;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  // Output logic: next values for every registered output and counter
  always_comb begin
    w_smp_cnt_nxt = r_smp_cnt;
    w_phase_nxt   = r_phase;
    w_we_nxt      = 1'b0;
    w_addr_nxt    = r_addr;
    w_wd_nxt      = r_wd;
    w_clr_nxt     = 1'b0;
    w_s_nxt       = r_s;
    w_res_nxt     = r_res;
    w_frm_nxt     = r_frm;
    if (abort) begin
      w_smp_cnt_nxt = 3'd0;
      w_phase_nxt   = 4'd0;
      w_addr_nxt    = 3'd0;
      w_clr_nxt     = 1'b1;
      w_s_nxt       = 3'b000;
      w_res_nxt     = 1'b0;
    end else if (e) begin
      if (w_acc) begin
        w_we_nxt      = 1'b1;
        w_addr_nxt    = r_smp_cnt;
        w_wd_nxt      = x_in;
        w_smp_cnt_nxt = r_smp_cnt + 3'd1;
      end
      case (r_state)
        DRAIN: begin
          w_s_nxt     = 3'b001;
          w_phase_nxt = 4'd0;
        end
        STG0, STG1, STG2: begin
          if (w_hi_end) begin
            w_s_nxt     = 3'b000;
            w_phase_nxt = 4'd0;
          end else if (w_gap_end) begin
            w_phase_nxt = 4'd0;
            if (r_state == STG0)      w_s_nxt = 3'b010;
            else if (r_state == STG1) w_s_nxt = 3'b100;
            else                      w_res_nxt = 1'b1;
          end else begin
            w_phase_nxt = r_phase + 4'd1;
          end
        end
        DONE: begin
          if (res_rdy) begin
            w_res_nxt = 1'b0;
            w_frm_nxt = r_frm + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers and counters
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      r_smp_cnt <= 3'd0;
      r_phase   <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= 3'd0;
      r_wd      <= '0;
      r_clr     <= 1'b0;
      r_s       <= 3'b000;
      r_res     <= 1'b0;
      r_frm     <= 8'd0;
    end else begin
      r_smp_cnt <= w_smp_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_wd      <= w_wd_nxt;
      r_clr     <= w_clr_nxt;
      r_s       <= w_s_nxt;
      r_res     <= w_res_nxt;
      r_frm     <= w_frm_nxt;
    end
  end

  assign buf_we   = r_we;
  assign buf_addr = r_addr;
  assign buf_wd   = r_wd;
  assign buf_clr  = r_clr;
  assign s        = r_s;
  assign res_vld  = r_res;
  assign busy     = (r_state != LOAD);
  assign frm_cnt  = r_frm;

endmodule

// File: tb/tb_fft8_seq.sv
// tb_fft8_seq: two sequencer instances (default timing and STB_W=3/GAP=2) driven by random frames.
// Expected buffer writes and strobe/result timing are queued when stimulus is issued;
// a negedge monitor pops and compares whenever a write or a rising strobe/result appears.
module tb_fft8_seq;
  localparam int DW = 2;

  typedef struct { int cyc; int addr; int data; } wr_t;
  typedef struct { int kind; int cyc; int len; } ev_t;

  logic c = 1'b0;
  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  logic          r_n[2], e_i[2], ab_i[2], xv_i[2], rr_i[2];
  logic [DW-1:0] xin_i[2];
  logic          xr_o[2], we_o[2], clr_o[2], rv_o[2], busy_o[2];
  logic [2:0]    addr_o[2], s_o[2];
  logic [DW-1:0] wd_o[2];
  logic [7:0]    fc_o[2];

  int stbw[2];
  int gapw[2];
  int fcm[2];
  wr_t wq[2][$];
  ev_t evq[2][$];
  int checks = 0;
  int errors = 0;

  fft8_seq #(.DW(DW), .STB_W(1), .GAP(1)) u0 (
    .c(c), .r(r_n[0]), .e(e_i[0]), .abort(ab_i[0]), .x_in(xin_i[0]), .x_vld(xv_i[0]),
    .x_rdy(xr_o[0]), .buf_we(we_o[0]), .buf_addr(addr_o[0]), .buf_wd(wd_o[0]),
    .buf_clr(clr_o[0]), .s(s_o[0]), .res_vld(rv_o[0]), .res_rdy(rr_i[0]),
    .busy(busy_o[0]), .frm_cnt(fc_o[0]));

  fft8_seq #(.DW(DW), .STB_W(3), .GAP(2)) u1 (
    .c(c), .r(r_n[1]), .e(e_i[1]), .abort(ab_i[1]), .x_in(xin_i[1]), .x_vld(xv_i[1]),
    .x_rdy(xr_o[1]), .buf_we(we_o[1]), .buf_addr(addr_o[1]), .buf_wd(wd_o[1]),
    .buf_clr(clr_o[1]), .s(s_o[1]), .res_vld(rv_o[1]), .res_rdy(rr_i[1]),
    .busy(busy_o[1]), .frm_cnt(fc_o[1]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: writes and rising edges of s bits / res_vld are popped from the scoreboards
  logic [2:0] ps[2];
  logic       pr[2];
  int         rise_c[2][3];
  int         elen[2][3];
  always @(negedge c) begin
    for (int i = 0; i < 2; i++) begin
      if (r_n[i]) begin
        if (we_o[i]) begin
          if (wq[i].size() == 0) chk($sformatf("u%0d unexpected write", i), 1, 0);
          else begin
            wr_t w;
            w = wq[i].pop_front();
            chk($sformatf("u%0d write cycle", i), cyc, w.cyc);
            chk($sformatf("u%0d buf_addr", i), int'(addr_o[i]), w.addr);
            chk($sformatf("u%0d buf_wd", i), int'(wd_o[i]), w.data);
          end
        end
        for (int j = 0; j < 4; j++) begin
          logic nb, wb;
          nb = (j < 3) ? s_o[i][j] : rv_o[i];
          wb = (j < 3) ? ps[i][j] : pr[i];
          if (nb && !wb) begin
            if (evq[i].size() == 0) chk($sformatf("u%0d unexpected rise", i), j, -1);
            else begin
              ev_t ev;
              ev = evq[i].pop_front();
              chk($sformatf("u%0d rise kind", i), j, ev.kind);
              chk($sformatf("u%0d rise cycle k%0d", i, j), cyc, ev.cyc);
              if (j < 3) begin
                rise_c[i][j] = cyc;
                elen[i][j]   = ev.len;
              end
            end
          end
          if (j < 3 && !nb && wb)
            chk($sformatf("u%0d s[%0d] high length", i, j), cyc - rise_c[i][j], elen[i][j]);
        end
        if (s_o[i] != 3'b000) chk($sformatf("u%0d s one-hot", i), $countones(s_o[i]), 1);
      end
      ps[i] = s_o[i];
      pr[i] = rv_o[i];
    end
  end

  // mode: 0 back-to-back with data n%4, 1 x_vld every other cycle, 2 random x_vld, 3 back-to-back random data
  task automatic send_frame(input int i, input int mode, input int stall, output int k);
    int n, t, data, p, st;
    logic vld;
    n = 0; t = 0; k = -1;
    while (n < 8 && t < 400) begin
      if (mode == 1)      vld = (t % 2 == 0);
      else if (mode == 2) vld = 1'($urandom_range(0, 1));
      else                vld = 1'b1;
      data = (mode == 0) ? (n % 4) : int'($urandom_range(0, (1 << DW) - 1));
      xv_i[i]  = vld;
      xin_i[i] = data[DW-1:0];
      @(negedge c);
      if (vld && xr_o[i]) begin
        wq[i].push_back(wr_t'{cyc + 1, n, data});
        if (n == 7) k = cyc + 1;
        n++;
      end
      @(posedge c); #1;
      t++;
    end
    xv_i[i] = 1'b0;
    if (n < 8) begin
      chk($sformatf("u%0d frame load timeout", i), n, 8);
    end else begin
      p  = stbw[i] + gapw[i];
      st = stall ? 4 : 0;
      evq[i].push_back(ev_t'{0, k + 1, stbw[i]});
      evq[i].push_back(ev_t'{1, k + 1 + p, stbw[i] + st});
      evq[i].push_back(ev_t'{2, k + 1 + 2 * p + st, stbw[i]});
      evq[i].push_back(ev_t'{3, k + 1 + 3 * p + st, 0});
    end
  endtask

  task automatic finish_frame(input int i, input int hold);
    int cnt, good;
    cnt = 0; good = 0;
    while (!rv_o[i] && cnt < 300) begin
      @(posedge c); #1;
      cnt++;
    end
    if (!rv_o[i]) begin
      chk($sformatf("u%0d res_vld timeout", i), 0, 1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge c);
      if (rv_o[i] && !xr_o[i] && busy_o[i]) good++;
      @(posedge c); #1;
    end
    if (hold > 0) chk($sformatf("u%0d DONE hold cycles", i), good, hold);
    rr_i[i] = 1'b1;
    @(posedge c); #1;
    rr_i[i] = 1'b0;
    fcm[i] = (fcm[i] + 1) % 256;
    @(negedge c);
    chk($sformatf("u%0d x_rdy after take", i), int'(xr_o[i]), 1);
    chk($sformatf("u%0d res_vld after take", i), int'(rv_o[i]), 0);
    chk($sformatf("u%0d frm_cnt", i), int'(fc_o[i]), fcm[i]);
    chk($sformatf("u%0d pending writes", i), wq[i].size(), 0);
    chk($sformatf("u%0d pending events", i), evq[i].size(), 0);
    @(posedge c); #1;
  endtask

  task automatic run_frame(input int i, input int mode, input int stall, input int hold);
    int k, p;
    send_frame(i, mode, stall, k);
    if (k < 0) return;
    if (stall != 0) begin
      p = stbw[i] + gapw[i];
      while (cyc < k + 1 + p) begin
        @(posedge c); #1;
      end
      e_i[i] = 1'b0;
      repeat (4) @(posedge c);
      #1;
      chk($sformatf("u%0d s frozen while e low", i), int'(s_o[i]), 3'b010);
      e_i[i] = 1'b1;
    end
    finish_frame(i, hold);
  endtask

  // nacc samples accepted normally, then abort coincides with the next accept
  task automatic abort_frame(input int i, input int nacc);
    for (int n = 0; n < nacc; n++) begin
      xv_i[i]  = 1'b1;
      xin_i[i] = DW'(n);
      @(negedge c);
      if (xr_o[i]) wq[i].push_back(wr_t'{cyc + 1, n, n});
      @(posedge c); #1;
    end
    xv_i[i]  = 1'b1;
    xin_i[i] = DW'(3);
    ab_i[i]  = 1'b1;
    @(posedge c); #1;
    ab_i[i] = 1'b0;
    xv_i[i] = 1'b0;
    @(negedge c);
    chk($sformatf("u%0d buf_clr on abort", i), int'(clr_o[i]), 1);
    chk($sformatf("u%0d buf_we on abort", i), int'(we_o[i]), 0);
    chk($sformatf("u%0d busy after abort", i), int'(busy_o[i]), 0);
    chk($sformatf("u%0d buf_addr after abort", i), int'(addr_o[i]), 0);
    @(posedge c); #1;
    @(negedge c);
    chk($sformatf("u%0d buf_clr one cycle", i), int'(clr_o[i]), 0);
    @(posedge c); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    stbw[0] = 1; gapw[0] = 1;
    stbw[1] = 3; gapw[1] = 2;
    for (int i = 0; i < 2; i++) begin
      r_n[i] = 1'b1; e_i[i] = 1'b1; ab_i[i] = 1'b0; xv_i[i] = 1'b0;
      rr_i[i] = 1'b0; xin_i[i] = '0; fcm[i] = 0;
    end
    #1;
    for (int i = 0; i < 2; i++) r_n[i] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset x_rdy", i), int'(xr_o[i]), 0);
      chk($sformatf("u%0d reset buf_we/clr", i), int'({we_o[i], clr_o[i]}), 0);
      chk($sformatf("u%0d reset buf_addr/wd", i), int'({addr_o[i], wd_o[i]}), 0);
      chk($sformatf("u%0d reset s", i), int'(s_o[i]), 0);
      chk($sformatf("u%0d reset res_vld/busy", i), int'({rv_o[i], busy_o[i]}), 0);
      chk($sformatf("u%0d reset frm_cnt", i), int'(fc_o[i]), 0);
    end
    repeat (3) @(posedge c);
    #2;
    for (int i = 0; i < 2; i++) r_n[i] = 1'b1;
    @(posedge c); #1;
    chk("u0 x_rdy after reset release", int'(xr_o[0]), 1);

    run_frame(0, 0, 0, 0);
    run_frame(0, 2, 0, 10);
    run_frame(1, 1, 0, 0);
    run_frame(1, 2, 1, 0);
    abort_frame(0, 4);
    run_frame(0, 2, 0, 0);

    // asynchronous reset while s[2] is high
    send_frame(1, 3, 0, k);
    if (k >= 0) begin
      while (cyc < k + 1 + 2 * (stbw[1] + gapw[1]) + 1) begin
        @(posedge c); #1;
      end
      chk("u1 s[2] high before reset", int'(s_o[1]), 3'b100);
      r_n[1] = 1'b0;
      #1;
      chk("u1 mid-frame reset s", int'(s_o[1]), 0);
      chk("u1 mid-frame reset res_vld", int'(rv_o[1]), 0);
      chk("u1 mid-frame reset x_rdy", int'(xr_o[1]), 0);
      chk("u1 mid-frame reset buf_clr", int'(clr_o[1]), 0);
      evq[1].delete();
      wq[1].delete();
      fcm[1] = 0;
      repeat (2) @(posedge c);
      #2;
      r_n[1] = 1'b1;
      @(negedge c);
      chk("u1 x_rdy after reset", int'(xr_o[1]), 1);
      chk("u1 busy after reset", int'(busy_o[1]), 0);
      chk("u1 frm_cnt after reset", int'(fc_o[1]), 0);
      @(posedge c); #1;
    end

    for (int f = 0; f < 256; f++) run_frame(1, 3, 0, 0);
    chk("u1 frm_cnt wrapped", int'(fc_o[1]), 0);

    repeat (4) @(posedge c);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
